// File: rtl/planificador_ascensor_if.sv
// Signal bundle between the elevator call scheduler and its surroundings:
// call buttons and floor sensor on one side, motor and door drivers on the other.
interface planificador_ascensor_if #(
  parameter int N_PISOS = 8
);
  localparam int W_PISO = $clog2(N_PISOS);

  logic [N_PISOS-1:0] llamada;
  logic               cambio_piso;
  logic               obstruccion;
  logic               subir;
  logic               bajar;
  logic               puerta_abierta;
  logic [W_PISO-1:0]  piso_actual;
  logic [N_PISOS-1:0] pendientes;
  logic               ocupado;

  // Environment side: presses buttons, reports floor arrivals, watches the cabin
  modport master (
    output llamada, cambio_piso, obstruccion,
    input  subir, bajar, puerta_abierta, piso_actual, pendientes, ocupado
  );

  // Scheduler side: consumes requests and sensors, drives motor and door
  modport slave (
    input  llamada, cambio_piso, obstruccion,
    output subir, bajar, puerta_abierta, piso_actual, pendientes, ocupado
  );
endinterface

// File: rtl/planificador_ascensor.sv
// SCAN-style elevator scheduler: latches floor calls, tracks the cabin floor
// from arrival pulses, runs the motor up/down and times the door-open interval.
module planificador_ascensor #(
  parameter int N_PISOS  = 8,
  parameter int T_PUERTA = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  planificador_ascensor_if.slave bus
);

  localparam int W_PISO = $clog2(N_PISOS);
  localparam int W_T    = $clog2(T_PUERTA);

  localparam logic [W_T-1:0]    T_RECARGA = W_T'(T_PUERTA - 1);
  localparam logic [W_PISO-1:0] PISO_MAX  = W_PISO'(N_PISOS - 1);
  localparam logic [W_PISO-1:0] PISO_MIN  = '0;

  typedef enum logic [1:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    PUERTA
  } estado_e;

  estado_e             estado_q, estado_d;
  logic                dir_q, dir_d;
  logic [W_T-1:0]      timer_q, timer_d;
  logic [W_PISO-1:0]   piso_q, piso_d;
  logic [N_PISOS-1:0]  pend_q, pend_d;

  logic                arriba;
  logic                abajo;
  logic [W_PISO-1:0]   piso_arriba;
  logic [W_PISO-1:0]   piso_abajo;
  logic [N_PISOS-1:0]  solicitado;
  logic [N_PISOS-1:0]  servido;
  logic [N_PISOS-1:0]  absorbido;

  // Pending-call summary relative to the cabin and the saturated neighbour floors
  always_comb begin
    arriba = 1'b0;
    abajo  = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (pend_q[i] && (W_PISO'(i) > piso_q)) arriba = 1'b1;
      if (pend_q[i] && (W_PISO'(i) < piso_q)) abajo  = 1'b1;
    end
    piso_arriba = (piso_q == PISO_MAX) ? piso_q : piso_q + W_PISO'(1);
    piso_abajo  = (piso_q == PISO_MIN) ? piso_q : piso_q - W_PISO'(1);
    solicitado  = pend_q | bus.llamada;
  end

  // State register: async active-low reset re-homes the cabin to floor 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      dir_q    <= 1'b1;
      timer_q  <= '0;
      piso_q   <= '0;
      pend_q   <= '0;
    end else begin
      estado_q <= estado_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      piso_q   <= piso_d;
      pend_q   <= pend_d;
    end
  end

  // Next-state logic: SCAN direction choice, floor stops and door timing
  always_comb begin
    estado_d  = estado_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    piso_d    = piso_q;
    servido   = '0;
    absorbido = '0;

    unique case (estado_q)
      REPOSO: begin
        if (pend_q[piso_q]) begin
          estado_d        = PUERTA;
          timer_d         = T_RECARGA;
          servido[piso_q] = 1'b1;
        end else if (dir_q && arriba) begin
          estado_d = SUBIENDO;
        end else if (!dir_q && abajo) begin
          estado_d = BAJANDO;
        end else if (arriba) begin
          estado_d = SUBIENDO;
          dir_d    = 1'b1;
        end else if (abajo) begin
          estado_d = BAJANDO;
          dir_d    = 1'b0;
        end
      end

      SUBIENDO: begin
        if (bus.cambio_piso) begin
          piso_d = piso_arriba;
          if (solicitado[piso_arriba]) begin
            estado_d             = PUERTA;
            timer_d              = T_RECARGA;
            servido[piso_arriba] = 1'b1;
          end
        end
      end

      BAJANDO: begin
        if (bus.cambio_piso) begin
          piso_d = piso_abajo;
          if (solicitado[piso_abajo]) begin
            estado_d            = PUERTA;
            timer_d             = T_RECARGA;
            servido[piso_abajo] = 1'b1;
          end
        end
      end

      PUERTA: begin
        absorbido[piso_q] = 1'b1;
        if (bus.obstruccion) begin
          timer_d = T_RECARGA;
        end else if (timer_q == '0) begin
          estado_d = REPOSO;
        end else begin
          timer_d = timer_q - W_T'(1);
        end
      end
    endcase

    pend_d = (pend_q | (bus.llamada & ~absorbido)) & ~servido;
  end

  // Moore outputs decoded from the current state and registers
  always_comb begin
    bus.subir          = (estado_q == SUBIENDO);
    bus.bajar          = (estado_q == BAJANDO);
    bus.puerta_abierta = (estado_q == PUERTA);
    bus.ocupado        = (estado_q != REPOSO);
    bus.piso_actual    = piso_q;
    bus.pendientes     = pend_q;
  end

endmodule

// File: tb/tb_planificador_ascensor.sv
// Directed scoreboard bench for the elevator scheduler: every step pushes the
// outputs it should produce, advances one clock and drains the queue against the DUT.
module tb_planificador_ascensor;

  localparam int N = 8;
  localparam int T = 16;

  typedef enum int {
    SEL_SUBIR,
    SEL_BAJAR,
    SEL_PUERTA,
    SEL_PISO,
    SEL_PEND,
    SEL_OCUP
  } sel_e;

  logic clk;
  logic rst_n;

  planificador_ascensor_if #(.N_PISOS(N)) bus ();

  planificador_ascensor #(
    .N_PISOS (N),
    .T_PUERTA(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  sel_e        selQ[$];
  logic [31:0] valQ[$];
  string       tagQ[$];

  int total;
  int bad;
  int abiertos;
  int pasos;

  // Free-running clock, rising edge every 10 time units
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select one DUT output, zero-extended, for comparison
  function automatic logic [31:0] observe(input sel_e s);
    logic [31:0] r;
    r = '0;
    case (s)
      SEL_SUBIR:  r = 32'(bus.subir);
      SEL_BAJAR:  r = 32'(bus.bajar);
      SEL_PUERTA: r = 32'(bus.puerta_abierta);
      SEL_PISO:   r = 32'(bus.piso_actual);
      SEL_PEND:   r = 32'(bus.pendientes);
      SEL_OCUP:   r = 32'(bus.ocupado);
      default:    r = '1;
    endcase
    return r;
  endfunction

  // Queue one expected output value
  task automatic expectOut(input sel_e s, input logic [31:0] v, input string tag);
    selQ.push_back(s);
    valQ.push_back(v);
    tagQ.push_back(tag);
  endtask

  // Queue the full expected output picture; ocupado follows from the motion/door flags
  task automatic expectAll(input logic s, input logic b, input logic p,
                           input logic [31:0] piso, input logic [31:0] pend,
                           input string tag);
    expectOut(SEL_SUBIR,  32'(s), {tag, ".subir"});
    expectOut(SEL_BAJAR,  32'(b), {tag, ".bajar"});
    expectOut(SEL_PUERTA, 32'(p), {tag, ".puerta"});
    expectOut(SEL_PISO,   piso,   {tag, ".piso"});
    expectOut(SEL_PEND,   pend,   {tag, ".pend"});
    expectOut(SEL_OCUP,   32'(s | b | p), {tag, ".ocupado"});
  endtask

  // Drive inputs at the falling edge and move to the next falling edge
  task automatic applyStimulus(input logic [N-1:0] l, input logic c, input logic o);
    bus.llamada     = l;
    bus.cambio_piso = c;
    bus.obstruccion = o;
    @(negedge clk);
  endtask

  // Drain the scoreboard against the DUT and check motor exclusivity
  task automatic checkOutput();
    sel_e        s;
    logic [31:0] v;
    logic [31:0] obs;
    string       tag;
    while (selQ.size() > 0) begin
      s   = selQ.pop_front();
      v   = valQ.pop_front();
      tag = tagQ.pop_front();
      obs = observe(s);
      total++;
      assert (obs === v) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, v);
      end
    end
    total++;
    assert ((bus.subir & bus.bajar) === 1'b0) else begin
      bad++;
      $error("[TB] FAIL motorExcl observed=%0b expected=0", bus.subir & bus.bajar);
    end
  endtask

  // One scoreboarded cycle: push expectations, drive, compare
  task automatic stepExpect(input logic [N-1:0] l, input logic c, input logic o,
                            input logic s, input logic b, input logic p,
                            input logic [31:0] piso, input logic [31:0] pend,
                            input string tag);
    expectAll(s, b, p, piso, pend, tag);
    applyStimulus(l, c, o);
    checkOutput();
  endtask

  // Idle cycles during which the door must stay open
  task automatic doorHold(input int n, input logic [31:0] piso,
                          input logic [31:0] pend, input string tag);
    for (int i = 0; i < n; i++) begin
      stepExpect('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, piso, pend, tag);
    end
  endtask

  // Directed scenario sequence
  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.llamada     = '0;
    bus.cambio_piso = 1'b0;
    bus.obstruccion = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expectAll(0, 0, 0, 0, 0, "reset");
    checkOutput();
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Call at the current floor opens the door without motion; re-press is absorbed
    stepExpect(8'h01, 0, 0, 0, 0, 0, 0, 8'h01, "t2Latch");
    stepExpect(8'h00, 0, 0, 0, 0, 1, 0, 8'h00, "t2Open");
    stepExpect(8'h01, 0, 0, 0, 0, 1, 0, 8'h00, "t2Absorb");
    doorHold(14, 0, 0, "t2Door");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 0, 8'h00, "t2Closed");

    // Single call to floor 4: latch, start up, four arrivals, 16-cycle door
    stepExpect(8'h10, 0, 0, 0, 0, 0, 0, 8'h10, "t1Latch");
    stepExpect(8'h00, 0, 0, 1, 0, 0, 0, 8'h10, "t1Up");
    for (int f = 1; f <= 3; f++) begin
      stepExpect(8'h00, 1, 0, 1, 0, 0, f, 8'h10, "t1Move");
    end
    stepExpect(8'h00, 1, 0, 0, 0, 1, 4, 8'h00, "t1Stop");
    doorHold(15, 4, 0, "t1Door");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 4, 8'h00, "t1Idle");
    stepExpect(8'h00, 1, 0, 0, 0, 0, 4, 8'h00, "ignoreCambio");

    // Call for floor 5 arrives with the pulse that reaches floor 5
    stepExpect(8'h80, 0, 0, 0, 0, 0, 4, 8'h80, "t5Latch");
    stepExpect(8'h00, 0, 0, 1, 0, 0, 4, 8'h80, "t5Up");
    stepExpect(8'h20, 1, 0, 0, 0, 1, 5, 8'h80, "t5Stop");
    doorHold(15, 5, 8'h80, "t5Door");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 5, 8'h80, "t5Gap");
    stepExpect(8'h00, 0, 0, 1, 0, 0, 5, 8'h80, "t5Resume");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 6, 8'h80, "t5Move");
    stepExpect(8'h00, 1, 0, 0, 0, 1, 7, 8'h00, "t5Top");
    doorHold(15, 7, 0, "t5Door2");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 7, 8'h00, "t5Idle");

    // Obstruction held 10 cycles starting on the last open cycle (door cycle 15)
    stepExpect(8'h80, 0, 0, 0, 0, 0, 7, 8'h80, "obLatch");
    stepExpect(8'h00, 0, 0, 0, 0, 1, 7, 8'h00, "obOpen");
    abiertos = 1;
    pasos    = 0;
    while (pasos < 100) begin
      applyStimulus('0, 1'b0, (pasos >= 15) && (pasos < 25));
      pasos++;
      if (bus.puerta_abierta) abiertos++;
      else break;
    end
    total++;
    assert (abiertos === 41) else begin
      bad++;
      $error("[TB] FAIL obLength observed=%0d expected=41", abiertos);
    end
    expectAll(0, 0, 0, 7, 0, "obClosed");
    checkOutput();

    // Fresh reset, then park the cabin at floor 3 heading up
    rst_n = 1'b0;
    @(negedge clk);
    expectAll(0, 0, 0, 0, 0, "rst2");
    checkOutput();
    rst_n = 1'b1;
    stepExpect(8'h08, 0, 0, 0, 0, 0, 0, 8'h08, "t3Park");
    stepExpect(8'h00, 0, 0, 1, 0, 0, 0, 8'h08, "t3ParkUp");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 1, 8'h08, "t3ParkMove");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 2, 8'h08, "t3ParkMove");
    stepExpect(8'h00, 1, 0, 0, 0, 1, 3, 8'h00, "t3ParkStop");
    doorHold(15, 3, 0, "t3ParkDoor");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 3, 8'h00, "t3ParkIdle");

    // Calls at 1 and 6 together: SCAN serves 6 first, then reverses to 1
    stepExpect(8'h42, 0, 0, 0, 0, 0, 3, 8'h42, "t3Latch");
    stepExpect(8'h00, 0, 0, 1, 0, 0, 3, 8'h42, "t3Up");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 4, 8'h42, "t3MoveUp");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 5, 8'h42, "t3MoveUp");
    stepExpect(8'h00, 1, 0, 0, 0, 1, 6, 8'h02, "t3Stop6");
    doorHold(15, 6, 8'h02, "t3Door6");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 6, 8'h02, "t3Gap");
    stepExpect(8'h00, 0, 0, 0, 1, 0, 6, 8'h02, "t3Down");
    for (int f = 5; f >= 2; f--) begin
      stepExpect(8'h00, 1, 0, 0, 1, 0, f, 8'h02, "t3MoveDown");
    end
    stepExpect(8'h00, 1, 0, 0, 0, 1, 1, 8'h00, "t3Stop1");
    doorHold(15, 1, 0, "t3Door1");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 1, 8'h00, "t3Idle");

    // Go up to 4, then head down toward 0 and reset while travelling at floor 2
    stepExpect(8'h10, 0, 0, 0, 0, 0, 1, 8'h10, "rsLatch4");
    stepExpect(8'h00, 0, 0, 1, 0, 0, 1, 8'h10, "rsUp");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 2, 8'h10, "rsMoveUp");
    stepExpect(8'h00, 1, 0, 1, 0, 0, 3, 8'h10, "rsMoveUp");
    stepExpect(8'h00, 1, 0, 0, 0, 1, 4, 8'h00, "rsStop4");
    doorHold(15, 4, 0, "rsDoor4");
    stepExpect(8'h00, 0, 0, 0, 0, 0, 4, 8'h00, "rsGap");
    stepExpect(8'h01, 0, 0, 0, 0, 0, 4, 8'h01, "rsLatch0");
    stepExpect(8'h00, 0, 0, 0, 1, 0, 4, 8'h01, "rsDown");
    stepExpect(8'h00, 1, 0, 0, 1, 0, 3, 8'h01, "rsMoveDown");
    stepExpect(8'h00, 1, 0, 0, 1, 0, 2, 8'h01, "rsMoveDown");
    bus.cambio_piso = 1'b0;
    expectAll(0, 0, 0, 0, 0, "asyncReset");
    #2 rst_n = 1'b0;
    #1 checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
